// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RV32 control unit.
// Covers FSM states, opcodes, ALU operations and datapath mux selects.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_DATA      = 2'b01,
      RES_ALURESULT = 2'b10,
      RES_IMM       = 2'b11
   } result_src_t;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // Successor of DECODE for a given opcode; anything unrecognised traps.
   function automatic state_t decode_next(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE: return S_MEMADR;
         OP_RTYPE:          return S_EXECR;
         OP_ITYPE:          return S_EXECI;
         OP_BRANCH:         return S_BRANCH;
         OP_JAL:            return S_JAL;
         OP_JALR:           return S_JALR;
         OP_LUI:            return S_LUI;
         default:           return S_TRAP;
      endcase
   endfunction

   function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                         input logic lt, input logic ltu);
      case (funct3)
         3'b000:  return zero;
         3'b001:  return ~zero;
         3'b100:  return lt;
         3'b101:  return ~lt;
         3'b110:  return ltu;
         3'b111:  return ~ltu;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU operation decode from funct3/funct7 for R- and I-type ops.
// Subtract is only possible for R-type (op bit 5), so addi never subtracts.
module alu_decoder
   import multicycle_control_pkg::*;
(
   input  logic       op5_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_i,
   output alu_op_t    alu_op_o
);

   always_comb begin
      alu_op_o = ALU_ADD;
      case (funct3_i)
         3'b000:  alu_op_o = (op5_i & funct7_i) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_op_o = ALU_SLL;
         3'b010:  alu_op_o = ALU_SLT;
         3'b011:  alu_op_o = ALU_SLTU;
         3'b100:  alu_op_o = ALU_XOR;
         3'b101:  alu_op_o = funct7_i ? ALU_SRA : ALU_SRL;
         3'b110:  alu_op_o = ALU_OR;
         default: alu_op_o = ALU_AND;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: drives datapath selects and enables per state.
// All outputs are forced low while rst_i is high, without waiting for a clock.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int ALU_CTRL_W  = 4,
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [6:0]            op_i,
   input  logic [2:0]            funct3_i,
   input  logic                  funct7_i,
   input  logic                  Zero_i,
   input  logic                  Lt_i,
   input  logic                  Ltu_i,
   input  logic                  mem_ready_i,
   output logic                  PCWrite_o,
   output logic                  AdrSrc_o,
   output logic                  MemRead_o,
   output logic                  MemWrite_o,
   output logic                  IRWrite_o,
   output logic                  RegWrite_o,
   output logic [1:0]            ResultSrc_o,
   output logic [1:0]            ALUSrcA_o,
   output logic [1:0]            ALUSrcB_o,
   output logic [2:0]            ImmSrc_o,
   output logic [ALU_CTRL_W-1:0] ALUControl_o,
   output logic                  illegal_o,
   output logic [3:0]            state_o
);

   state_t  state_q, state_d;
   logic    illegal_q, illegal_d;
   logic    jalr_q, jalr_d;
   logic    mem_ready;
   alu_op_t dec_alu_op;
   alu_op_t alu_sel;

   assign mem_ready = MEM_WAIT_EN ? mem_ready_i : 1'b1;

   alu_decoder u_alu_decoder (
      .op5_i    (op_i[5]),
      .funct3_i (funct3_i),
      .funct7_i (funct7_i),
      .alu_op_o (dec_alu_op)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         jalr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         jalr_q    <= jalr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      illegal_d   = illegal_q;
      jalr_d      = jalr_q;
      PCWrite_o   = 1'b0;
      AdrSrc_o    = 1'b0;
      MemRead_o   = 1'b0;
      MemWrite_o  = 1'b0;
      IRWrite_o   = 1'b0;
      RegWrite_o  = 1'b0;
      ResultSrc_o = RES_ALUOUT;
      ALUSrcA_o   = SRCA_PC;
      ALUSrcB_o   = SRCB_RS2;
      ImmSrc_o    = IMM_I;
      alu_sel     = ALU_ADD;

      case (state_q)
         S_FETCH: begin
            jalr_d      = 1'b0;
            MemRead_o   = 1'b1;
            ALUSrcB_o   = SRCB_FOUR;
            ResultSrc_o = RES_ALURESULT;
            if (mem_ready) begin
               IRWrite_o = 1'b1;
               PCWrite_o = 1'b1;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            // Speculative branch target, latched into ALUOut for BRANCH.
            ALUSrcA_o = SRCA_OLDPC;
            ALUSrcB_o = SRCB_IMM;
            ImmSrc_o  = IMM_B;
            state_d   = decode_next(op_i);
            if (decode_next(op_i) == S_TRAP) begin
               illegal_d = 1'b1;
            end
         end
         S_MEMADR: begin
            ALUSrcA_o = SRCA_RS1;
            ALUSrcB_o = SRCB_IMM;
            ImmSrc_o  = op_i[5] ? IMM_S : IMM_I;
            state_d   = op_i[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            MemRead_o = 1'b1;
            AdrSrc_o  = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWRITE: begin
            MemWrite_o = 1'b1;
            AdrSrc_o   = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_MEMWB: begin
            RegWrite_o  = 1'b1;
            ResultSrc_o = RES_DATA;
            state_d     = S_FETCH;
         end
         S_EXECR: begin
            ALUSrcA_o = SRCA_RS1;
            ALUSrcB_o = SRCB_RS2;
            alu_sel   = dec_alu_op;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA_o = SRCA_RS1;
            ALUSrcB_o = SRCB_IMM;
            ImmSrc_o  = IMM_I;
            alu_sel   = dec_alu_op;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite_o  = 1'b1;
            ResultSrc_o = RES_ALUOUT;
            jalr_d      = 1'b0;
            if (jalr_q) begin
               PCWrite_o   = 1'b1;
               ResultSrc_o = RES_ALURESULT;
            end
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA_o = SRCA_RS1;
            ALUSrcB_o = SRCB_RS2;
            alu_sel   = ALU_SUB;
            PCWrite_o = branch_taken(funct3_i, Zero_i, Lt_i, Ltu_i);
            state_d   = S_FETCH;
         end
         S_JAL: begin
            PCWrite_o = 1'b1;
            ALUSrcA_o = SRCA_OLDPC;
            ALUSrcB_o = SRCB_FOUR;
            ImmSrc_o  = IMM_J;
            state_d   = S_ALUWB;
         end
         S_JALR: begin
            ALUSrcA_o = SRCA_RS1;
            ALUSrcB_o = SRCB_IMM;
            ImmSrc_o  = IMM_I;
            jalr_d    = 1'b1;
            state_d   = S_ALUWB;
         end
         S_LUI: begin
            RegWrite_o  = 1'b1;
            ResultSrc_o = RES_IMM;
            ImmSrc_o    = IMM_U;
            state_d     = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // Registered state only clears on the reset edge; outputs must drop at once.
      if (rst_i) begin
         PCWrite_o   = 1'b0;
         AdrSrc_o    = 1'b0;
         MemRead_o   = 1'b0;
         MemWrite_o  = 1'b0;
         IRWrite_o   = 1'b0;
         RegWrite_o  = 1'b0;
         ResultSrc_o = 2'b00;
         ALUSrcA_o   = 2'b00;
         ALUSrcB_o   = 2'b00;
         ImmSrc_o    = 3'b000;
         alu_sel     = ALU_ADD;
      end
   end

   assign ALUControl_o = ALU_CTRL_W'(alu_sel);
   assign illegal_o    = illegal_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations,
// a monitor pops and compares them at each falling edge or on an async probe.
module tb_multicycle_control;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [6:0] op_i;
   logic [2:0] funct3_i;
   logic       funct7_i;
   logic       Zero_i, Lt_i, Ltu_i;
   logic       mem_ready_i;
   logic       PCWrite_o, AdrSrc_o, MemRead_o, MemWrite_o, IRWrite_o, RegWrite_o;
   logic [1:0] ResultSrc_o, ALUSrcA_o, ALUSrcB_o;
   logic [2:0] ImmSrc_o;
   logic [3:0] ALUControl_o;
   logic       illegal_o;
   logic [3:0] state_o;

   multicycle_control dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .op_i         (op_i),
      .funct3_i     (funct3_i),
      .funct7_i     (funct7_i),
      .Zero_i       (Zero_i),
      .Lt_i         (Lt_i),
      .Ltu_i        (Ltu_i),
      .mem_ready_i  (mem_ready_i),
      .PCWrite_o    (PCWrite_o),
      .AdrSrc_o     (AdrSrc_o),
      .MemRead_o    (MemRead_o),
      .MemWrite_o   (MemWrite_o),
      .IRWrite_o    (IRWrite_o),
      .RegWrite_o   (RegWrite_o),
      .ResultSrc_o  (ResultSrc_o),
      .ALUSrcA_o    (ALUSrcA_o),
      .ALUSrcB_o    (ALUSrcB_o),
      .ImmSrc_o     (ImmSrc_o),
      .ALUControl_o (ALUControl_o),
      .illegal_o    (illegal_o),
      .state_o      (state_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic [3:0]  state;
      logic [19:0] ctrl;
   } exp_t;

   exp_t sb[$];
   event sample_ev;
   int   checks = 0;
   int   passed = 0;

   logic [19:0] act_ctrl;
   assign act_ctrl = {PCWrite_o, AdrSrc_o, MemRead_o, MemWrite_o, IRWrite_o, RegWrite_o,
                      ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ImmSrc_o, ALUControl_o, illegal_o};

   // Field order: pcw adr mrd mwr irw rgw | rsrc srca srcb imm alu | illegal
   function automatic logic [19:0] cv(input logic pcw, input logic adr, input logic mrd,
                                      input logic mwr, input logic irw, input logic rgw,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sbs, input logic [2:0] imm,
                                      input logic [3:0] alu, input logic ill);
      return {pcw, adr, mrd, mwr, irw, rgw, rs, sa, sbs, imm, alu, ill};
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_i or sample_ev);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (state_o === e.state && act_ctrl === e.ctrl) begin
               passed++;
               $display("ok   %-16s state=%0d ctrl=%05h", e.name, state_o, act_ctrl);
            end else begin
               $display("FAIL %-16s got state=%0d ctrl=%05h, want state=%0d ctrl=%05h",
                        e.name, state_o, act_ctrl, e.state, e.ctrl);
            end
         end
      end
   end

   task automatic cyc(input string n, input logic rdy, input logic [3:0] st, input logic [19:0] c);
      mem_ready_i = rdy;
      sb.push_back('{name: n, state: st, ctrl: c});
      @(posedge clk_i);
      #1;
   endtask

   task automatic async_chk(input string n, input logic [3:0] st, input logic [19:0] c);
      sb.push_back('{name: n, state: st, ctrl: c});
      ->sample_ev;
      #1;
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input logic lt, input logic ltu);
      op_i = op; funct3_i = f3; funct7_i = f7; Zero_i = z; Lt_i = lt; Ltu_i = ltu;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit, got no finish, want finish");
      $fatal(1);
   end

   logic [19:0] F_RDY, F_WAIT, DEC, ZERO;

   initial begin : stimulus
      F_RDY  = cv(1,0,1,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0, 0);
      F_WAIT = cv(0,0,1,0,0,0, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0, 0);
      DEC    = cv(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b010, 4'd0, 0);
      ZERO   = 20'h0;

      rst_i = 1'b1;
      mem_ready_i = 1'b0;
      set_instr(7'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk_i);
      #1;
      async_chk("reset", 4'd0, ZERO);
      rst_i = 1'b0;

      // add x3,x1,x2 = 0x002081B3
      set_instr(7'h33, 3'b000, 1'b0, 0, 0, 0);
      cyc("add_fetch", 1, 4'd0, F_RDY);
      cyc("add_decode", 1, 4'd1, DEC);
      cyc("add_execr", 1, 4'd6, cv(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd0, 0));
      cyc("add_aluwb", 1, 4'd8, cv(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0));

      set_instr(7'h33, 3'b000, 1'b1, 0, 0, 0);
      cyc("sub_fetch", 1, 4'd0, F_RDY);
      cyc("sub_decode", 1, 4'd1, DEC);
      cyc("sub_execr", 1, 4'd6, cv(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1, 0));
      cyc("sub_aluwb", 1, 4'd8, cv(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0));

      set_instr(7'h13, 3'b000, 1'b1, 0, 0, 0);
      cyc("addi_fetch", 1, 4'd0, F_RDY);
      cyc("addi_decode", 1, 4'd1, DEC);
      cyc("addi_execi", 1, 4'd7, cv(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0, 0));
      cyc("addi_aluwb", 1, 4'd8, cv(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0));

      // srai: funct3 101 with funct7 set selects sra
      set_instr(7'h13, 3'b101, 1'b1, 0, 0, 0);
      cyc("srai_fetch", 1, 4'd0, F_RDY);
      cyc("srai_decode", 1, 4'd1, DEC);
      cyc("srai_execi", 1, 4'd7, cv(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd9, 0));
      cyc("srai_aluwb", 1, 4'd8, cv(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0));

      set_instr(7'h03, 3'b010, 1'b0, 0, 0, 0);
      cyc("lw_fetch_wait", 0, 4'd0, F_WAIT);
      cyc("lw_fetch", 1, 4'd0, F_RDY);
      cyc("lw_decode", 1, 4'd1, DEC);
      cyc("lw_memadr", 1, 4'd2, cv(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0, 0));
      for (int i = 0; i < 3; i++)
         cyc("lw_memread_wait", 0, 4'd3, cv(0,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0));
      cyc("lw_memread_done", 1, 4'd3, cv(0,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0));
      cyc("lw_memwb", 1, 4'd4, cv(0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 3'b000, 4'd0, 0));

      set_instr(7'h63, 3'b100, 1'b0, 0, 1, 0);
      cyc("blt_fetch", 1, 4'd0, F_RDY);
      cyc("blt_decode", 1, 4'd1, DEC);
      cyc("blt_branch", 1, 4'd9, cv(1,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1, 0));

      set_instr(7'h63, 3'b111, 1'b0, 0, 0, 1);
      cyc("bgeu_fetch", 1, 4'd0, F_RDY);
      cyc("bgeu_decode", 1, 4'd1, DEC);
      cyc("bgeu_branch", 1, 4'd9, cv(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1, 0));

      // funct3 010 is never taken even with every flag set
      set_instr(7'h63, 3'b010, 1'b0, 1, 1, 1);
      cyc("b010_fetch", 1, 4'd0, F_RDY);
      cyc("b010_decode", 1, 4'd1, DEC);
      cyc("b010_branch", 1, 4'd9, cv(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1, 0));

      set_instr(7'h67, 3'b000, 1'b0, 0, 0, 0);
      cyc("jalr_fetch", 1, 4'd0, F_RDY);
      cyc("jalr_decode", 1, 4'd1, DEC);
      cyc("jalr_jalr", 1, 4'd11, cv(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0, 0));
      cyc("jalr_aluwb", 1, 4'd8, cv(1,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 3'b000, 4'd0, 0));

      set_instr(7'h6F, 3'b000, 1'b0, 0, 0, 0);
      cyc("jal_fetch", 1, 4'd0, F_RDY);
      cyc("jal_decode", 1, 4'd1, DEC);
      cyc("jal_jal", 1, 4'd10, cv(1,0,0,0,0,0, 2'b00, 2'b01, 2'b10, 3'b011, 4'd0, 0));
      cyc("jal_aluwb", 1, 4'd8, cv(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0));

      set_instr(7'h37, 3'b000, 1'b0, 0, 0, 0);
      cyc("lui_fetch", 1, 4'd0, F_RDY);
      cyc("lui_decode", 1, 4'd1, DEC);
      cyc("lui_lui", 1, 4'd12, cv(0,0,0,0,0,1, 2'b11, 2'b00, 2'b00, 3'b100, 4'd0, 0));

      // sw interrupted by reset while waiting in MEMWRITE
      set_instr(7'h23, 3'b010, 1'b0, 0, 0, 0);
      cyc("sw_fetch", 1, 4'd0, F_RDY);
      cyc("sw_decode", 1, 4'd1, DEC);
      cyc("sw_memadr", 1, 4'd2, cv(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0, 0));
      cyc("sw_memwrite", 0, 4'd5, cv(0,1,0,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0));
      rst_i = 1'b1;
      #1;
      async_chk("sw_async_rst", 4'd0, ZERO);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      cyc("sw_restart_fetch", 0, 4'd0, F_WAIT);
      cyc("sw2_fetch", 1, 4'd0, F_RDY);
      cyc("sw2_decode", 1, 4'd1, DEC);
      cyc("sw2_memadr", 1, 4'd2, cv(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0, 0));
      cyc("sw2_memwrite", 1, 4'd5, cv(0,1,0,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0));
      cyc("sw2_next_fetch", 0, 4'd0, F_WAIT);

      set_instr(7'h7F, 3'b000, 1'b0, 0, 0, 0);
      cyc("trap_fetch", 1, 4'd0, F_RDY);
      cyc("trap_decode", 1, 4'd1, DEC);
      for (int i = 0; i < 3; i++)
         cyc("trap_hold", 1, 4'd13, cv(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 1));
      rst_i = 1'b1;
      #1;
      async_chk("trap_async_rst", 4'd0, ZERO);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      set_instr(7'h33, 3'b000, 1'b0, 0, 0, 0);
      cyc("post_trap_fetch", 1, 4'd0, F_RDY);
      cyc("post_trap_decode", 1, 4'd1, DEC);

      repeat (2) @(posedge clk_i);
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
